// File: rtl/mips_ctrl_pkg.sv
// Shared types and codes for the multi-cycle MIPS control unit.
// Opcodes, FSM state encoding, mux select codes and control word.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_RD    = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WR    = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11
  } state_t;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
  } ctrl_t;

  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

  function automatic logic op_legal(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Control word decoder for the multi-cycle MIPS sequencer.
// Pure combinational: state plus mem_ready/zero qualification.
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  state_t state_i,
  input  logic   mem_ready_i,
  input  logic   zero_i,
  output ctrl_t  ctrl_o
);

  // Per-state control word; unlisted fields stay 0.
  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALU_ADD;
        ctrl_o.pc_source = PC_ALU;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      S_DECODE: begin
        ctrl_o.alu_src_b = SRCB_IMM_SH;
        ctrl_o.alu_op    = ALU_ADD;
      end
      S_MEM_ADDR, S_ADDI_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.iord     = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_MEM_WR: begin
        ctrl_o.mem_write  = 1'b1;
        ctrl_o.iord       = 1'b1;
        ctrl_o.instr_done = mem_ready_i;
      end
      S_R_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_RT;
        ctrl_o.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.reg_dst    = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_ADDI_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a  = 1'b1;
        ctrl_o.alu_src_b  = SRCB_RT;
        ctrl_o.alu_op     = ALU_SUB;
        ctrl_o.pc_source  = PC_ALUOUT;
        ctrl_o.pc_write   = zero_i;
        ctrl_o.instr_done = 1'b1;
      end
      S_JUMP: begin
        ctrl_o.pc_source  = PC_JUMP;
        ctrl_o.pc_write   = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS sequencer: state register, next state, wait counter.
// Outputs are forced low while reset is held so no strobe leaks out.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       mem_timeout
);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       timeout_q, timeout_d;
  logic       waiting;
  logic       illegal;
  ctrl_t      ctrl, ctrl_g;

  mips_ctrl_outdec u_outdec (
    .state_i     (state_q),
    .mem_ready_i (mem_ready),
    .zero_i      (zero),
    .ctrl_o      (ctrl)
  );

  // State, wait counter and sticky timeout registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      cnt_q     <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state sequencing; mem_ready only matters in memory states.
  always_comb begin
    state_d = state_q;
    illegal = 1'b0;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE:     state_d = S_R_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDI_EXEC;
          default: begin
            state_d = S_FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR:
        state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:    if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WR:    if (mem_ready) state_d = S_FETCH;
      S_R_EXEC:    state_d = S_R_WB;
      S_R_WB:      state_d = S_FETCH;
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      S_ADDI_WB:   state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_JUMP:      state_d = S_FETCH;
      default:     state_d = S_FETCH;
    endcase
  end

  // Count wait cycles; any non-wait cycle clears so entry starts at 0.
  always_comb begin
    waiting   = is_mem_state(state_q) && !mem_ready;
    cnt_d     = 8'd0;
    timeout_d = timeout_q;
    if (waiting) begin
      cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
      if (32'(cnt_d) >= MAX_WAIT) timeout_d = 1'b1;
    end
  end

  // Gate the control word with reset so an in-flight request drops at once.
  always_comb begin
    ctrl_g = rst_n ? ctrl : '0;
  end

  assign pc_write    = ctrl_g.pc_write;
  assign ir_write    = ctrl_g.ir_write;
  assign iord        = ctrl_g.iord;
  assign mem_read    = ctrl_g.mem_read;
  assign mem_write   = ctrl_g.mem_write;
  assign mem_to_reg  = ctrl_g.mem_to_reg;
  assign reg_dst     = ctrl_g.reg_dst;
  assign reg_write   = ctrl_g.reg_write;
  assign alu_src_a   = ctrl_g.alu_src_a;
  assign alu_src_b   = ctrl_g.alu_src_b;
  assign alu_op      = ctrl_g.alu_op;
  assign pc_source   = ctrl_g.pc_source;
  assign instr_done  = ctrl_g.instr_done;
  assign illegal_op  = rst_n & illegal;
  assign mem_timeout = timeout_q;

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multi-cycle sequencer for the 32-bit MIPS datapath. It replaces the single-cycle opcode decoder. It steps each instruction through fetch, decode, execute, memory and write-back states, drives every datapath mux select and write strobe, and stalls on a shared instruction/data memory through a ready handshake. It sits between the instruction register opcode field, the ALU zero flag and the memory port, and the datapath registers: PC, IR, register file, data memory.

## Interface
Parameters:
- `MAX_WAIT`, default 255: memory wait-cycle limit before `mem_timeout` is raised.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `opcode`, in, 6: IR[31:26], valid from DECODE onward.
- `zero`, in, 1: ALU zero flag.
- `mem_ready`, in, 1: memory completes the current access this cycle.
- `pc_write`, out, 1: PC load strobe.
- `ir_write`, out, 1: IR load strobe.
- `iord`, out, 1: memory address select, 0 = PC, 1 = ALUOut.
- `mem_read`, `mem_write`, out, 1 each: memory request.
- `mem_to_reg`, out, 1: 1 = write-back from MDR.
- `reg_dst`, out, 1: 1 = rd, 0 = rt.
- `reg_write`, out, 1: register file write strobe.
- `alu_src_a`, out, 1: 0 = PC, 1 = rs.
- `alu_src_b`, out, 2: 00 = rt, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm << 2.
- `alu_op`, out, 2: 00 = add, 01 = sub, 10 = funct.
- `pc_source`, out, 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `instr_done`, out, 1: one-cycle pulse in the final state of each instruction.
- `illegal_op`, out, 1: one-cycle pulse in DECODE when the opcode is unsupported.
- `mem_timeout`, out, 1: sticky flag; cleared only by reset.

## Operation
- Opcodes: R-type 0x00, lw 0x23, sw 0x2B, beq 0x04, j 0x02, addi 0x08.
- States use a 4-bit encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EXEC=10, ADDI_WB=11.
- FETCH
  - Drives `mem_read`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00, `pc_source`=00.
  - Holds until `mem_ready`. In the ready cycle, `ir_write`=1 and `pc_write`=1, then goes to DECODE.
- DECODE
  - Drives `alu_src_a`=0, `alu_src_b`=11, `alu_op`=00 (branch target into ALUOut).
  - lw/sw go to MEM_ADDR, R-type to R_EXEC, beq to BRANCH, j to JUMP, addi to ADDI_EXEC.
  - Any other opcode pulses `illegal_op` and returns to FETCH.
- MEM_ADDR: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. Goes to MEM_RD for lw, MEM_WR for sw.
- MEM_RD: `mem_read`=1, `iord`=1. Holds until `mem_ready`, then goes to MEM_WB.
- MEM_WB: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0, `instr_done`=1, then FETCH.
- MEM_WR: `mem_write`=1, `iord`=1. Holds until `mem_ready`. `instr_done`=1 in the ready cycle, then FETCH.
- R_EXEC (`alu_src_a`=1, `alu_src_b`=00, `alu_op`=10) goes to R_WB. R_WB drives `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0, `instr_done`=1.
- ADDI_EXEC (`alu_src_a`=1, `alu_src_b`=10, `alu_op`=00) goes to ADDI_WB. ADDI_WB drives `reg_write`=1, `reg_dst`=0, `instr_done`=1.
- BRANCH
  - Drives `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_source`=01, `pc_write`=`zero`, `instr_done`=1.
  - Goes to FETCH.
- JUMP: `pc_source`=10, `pc_write`=1, `instr_done`=1, then FETCH.
- Any signal not listed for a state is 0 in that state.
- Unused state codes 12..15 return to FETCH with all outputs 0.

## Timing
- Outputs are combinational from the current state, plus `mem_ready`/`zero` qualification; there are no output registers.
- Cycles per instruction with zero wait states: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3. Each wait cycle adds 1 to FETCH, MEM_RD or MEM_WR.
- A memory request stays asserted with a stable `iord` until `mem_ready` is sampled high. `mem_ready` outside FETCH, MEM_RD and MEM_WR is ignored.
- Wait counter:
  - 8 bits; cleared on entry to any memory state; incremented per wait cycle and saturates.
  - Reaching `MAX_WAIT` sets `mem_timeout`. The state machine keeps waiting.
- While `rst_n`=0, every output is 0. The state is held at FETCH and the wait counter at 0.
- On `rst_n` rising, FETCH outputs appear in the first cycle.
- Reset asserted mid-instruction drops the in-flight request immediately. No partial write strobe is emitted.

## Structure
- Shared package `mips_ctrl_pkg` holds:
  - the opcode constants;
  - the 4-bit state type and its encodings;
  - the `alu_src_b`, `alu_op` and `pc_source` code constants.
- Sub-module `mips_ctrl_outdec` is a combinational decoder from state, `mem_ready` and `zero` to the control word.
- The top level holds the state register, next-state logic and wait counter.

## Test plan
- lw with `mem_ready` tied 1: state sequence 0,1,2,3,4,0. `reg_write`=1 with `mem_to_reg`=1 only in state 4. `instr_done` pulses at cycle 5.
- sw with 3 wait cycles in MEM_WR: `mem_write`=1 and `iord`=1 held for 4 cycles. `instr_done` rises only in the ready cycle. Total 7 cycles.
- beq twice:
  - `zero`=1: `pc_write`=1 with `pc_source`=01 in BRANCH.
  - `zero`=0: `pc_write` stays 0 and `instr_done` still pulses.
- opcode 0x3F: `illegal_op` pulses in DECODE, then FETCH. No `reg_write`, `mem_write` or `pc_write` pulse after the fetch.
- `MAX_WAIT`=4 and `mem_ready` held 0 in FETCH: `mem_timeout` sets after 4 wait cycles and stays set after `mem_ready` returns. `rst_n` pulse clears it.
- `rst_n` dropped during MEM_WR wait: `mem_write` goes 0 asynchronously. After release the machine is in FETCH with `mem_read`=1 and `iord`=0.
